// File: rtl/cve2_xif_pkg.sv
// Shared types and helpers for the CVE2 XIF offload tracker.
package cve2_xif_pkg;

  // Upper bound on tracker depth supported by this implementation.
  localparam int unsigned XIF_MAX_OUTSTANDING = 16;

  // One tracker slot. The wb field is always two bits wide. Bit 1 is only
  // ever set when register-pair writeback is enabled.
  typedef struct packed {
    logic       valid;
    logic       committed;
    logic [4:0] rd;
    logic [1:0] wb;
  } xif_entry_t;

  // Expand a register index to a 32-bit one-hot mask.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/cve2_xif_prio_enc.sv
// Lowest-set-bit encoder used to pick the next free offload ID.
module cve2_xif_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit wins last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cve2_xif_offload_tracker.sv
// Core-side tracker for XIF offloaded instructions: ID allocation,
// commit/kill/flush bookkeeping, result gating and the rd scoreboard.
module cve2_xif_offload_tracker
  import cve2_xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH        = 4,
  parameter int unsigned X_NUM_OUTSTANDING = 4,
  parameter int unsigned X_DUALWRITE       = 0,
  localparam int unsigned WB_W  = X_DUALWRITE + 1,
  localparam int unsigned CNT_W = $clog2(X_NUM_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  input  logic                  issue_ready_i,
  input  logic                  issue_accept_i,
  input  logic [WB_W-1:0]       issue_writeback_i,
  input  logic [4:0]            issue_rd_i,
  output logic [X_ID_WIDTH-1:0] issue_id_o,
  output logic                  issue_allow_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  flush_i,
  input  logic                  result_valid_i,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  output logic                  result_ready_o,
  input  logic                  wb_stall_i,
  output logic [4:0]            result_rd_o,
  output logic [WB_W-1:0]       result_we_o,
  output logic [31:0]           rd_pending_o,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  busy_o,
  output logic                  err_o
);

  xif_entry_t entry_q [X_NUM_OUTSTANDING];
  xif_entry_t entry_d [X_NUM_OUTSTANDING];
  xif_entry_t commit_e, result_e;
  logic [X_NUM_OUTSTANDING-1:0] free_vec;
  logic [X_ID_WIDTH-1:0] free_idx;
  logic free_found;
  logic issue_hs, issue_alloc, issue_full;
  logic commit_ok, commit_bad, result_ok, result_hs, result_bad;
  logic err_q;

  // Free-slot vector feeding the allocator.
  always_comb begin
    free_vec = '0;
    for (int i = 0; i < int'(X_NUM_OUTSTANDING); i++) free_vec[i] = ~entry_q[i].valid;
  end

  cve2_xif_prio_enc #(
    .N     (X_NUM_OUTSTANDING),
    .IDX_W (X_ID_WIDTH)
  ) u_free_enc (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  // Look up the entries named by commit and result IDs; out-of-range IDs read as invalid.
  always_comb begin
    commit_e = '0;
    result_e = '0;
    for (int i = 0; i < int'(X_NUM_OUTSTANDING); i++) begin
      if (commit_id_i == X_ID_WIDTH'(i)) commit_e = entry_q[i];
      if (result_id_i == X_ID_WIDTH'(i)) result_e = entry_q[i];
    end
  end

  assign issue_hs       = issue_valid_i & issue_ready_i;
  assign issue_alloc    = issue_hs & issue_accept_i & free_found;
  assign issue_full     = issue_hs & ~free_found;
  assign commit_ok      = commit_valid_i & commit_e.valid & ~commit_e.committed;
  assign commit_bad     = commit_valid_i & ~commit_ok;
  assign result_ok      = result_e.valid & result_e.committed;
  assign result_ready_o = result_ok & ~wb_stall_i;
  assign result_hs      = result_valid_i & result_ready_o;
  assign result_bad     = result_valid_i & ~result_ok;

  assign issue_id_o    = free_idx;
  assign issue_allow_o = free_found;
  assign result_rd_o   = result_e.rd;
  assign result_we_o   = result_e.wb[WB_W-1:0] & {WB_W{result_hs}};
  assign err_o         = err_q;

  // Per-entry next state: commit first, then flush, then result; allocation only touches free slots.
  always_comb begin
    for (int i = 0; i < int'(X_NUM_OUTSTANDING); i++) begin
      entry_d[i] = entry_q[i];
      if (commit_ok && commit_id_i == X_ID_WIDTH'(i)) begin
        if (commit_kill_i) entry_d[i].valid     = 1'b0;
        else               entry_d[i].committed = 1'b1;
      end
      if (flush_i && entry_d[i].valid && !entry_d[i].committed) entry_d[i].valid = 1'b0;
      if (result_hs && result_id_i == X_ID_WIDTH'(i)) entry_d[i].valid = 1'b0;
      if (issue_alloc && free_idx == X_ID_WIDTH'(i)) begin
        entry_d[i].valid     = 1'b1;
        entry_d[i].committed = 1'b0;
        entry_d[i].rd        = issue_rd_i;
        entry_d[i].wb        = 2'(issue_writeback_i);
      end
    end
  end

  // Tracker state and sticky error; rd/wb payload is left out of reset since valid guards it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(X_NUM_OUTSTANDING); i++) begin
        entry_q[i].valid     <= 1'b0;
        entry_q[i].committed <= 1'b0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(X_NUM_OUTSTANDING); i++) entry_q[i] <= entry_d[i];
      err_q <= err_q | commit_bad | result_bad | issue_full;
    end
  end

  // Pending-writeback scoreboard and occupancy count from registered entries.
  always_comb begin
    rd_pending_o  = '0;
    outstanding_o = '0;
    for (int i = 0; i < int'(X_NUM_OUTSTANDING); i++) begin
      if (entry_q[i].valid) begin
        outstanding_o = outstanding_o + CNT_W'(1);
        if (entry_q[i].wb[0]) rd_pending_o = rd_pending_o | rd_onehot(entry_q[i].rd);
        if (X_DUALWRITE != 0 && entry_q[i].wb[1])
          rd_pending_o = rd_pending_o | rd_onehot(entry_q[i].rd | 5'd1);
      end
    end
    rd_pending_o[0] = 1'b0;
  end

  assign busy_o = (outstanding_o != '0);

endmodule

// File: tb/tb_cve2_xif_offload_tracker.sv
module tb_cve2_xif_offload_tracker;

  localparam int IDW = 4;
  localparam int NUM = 4;
  localparam int DW  = 1;
  localparam int CW  = $clog2(NUM + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           issue_valid, issue_ready, issue_accept;
  logic [DW:0]    issue_wb;
  logic [4:0]     issue_rd;
  logic [IDW-1:0] issue_id;
  logic           issue_allow;
  logic           commit_valid;
  logic [IDW-1:0] commit_id;
  logic           commit_kill;
  logic           flush;
  logic           result_valid;
  logic [IDW-1:0] result_id;
  logic           result_ready;
  logic           wb_stall;
  logic [4:0]     result_rd;
  logic [DW:0]    result_we;
  logic [31:0]    rd_pending;
  logic [CW-1:0]  outstanding;
  logic           busy;
  logic           err;

  typedef struct {
    logic [4:0]  rd;
    logic [DW:0] we;
  } exp_res_t;
  exp_res_t sb_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cve2_xif_offload_tracker #(
    .X_ID_WIDTH        (IDW),
    .X_NUM_OUTSTANDING (NUM),
    .X_DUALWRITE       (DW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .issue_valid_i     (issue_valid),
    .issue_ready_i     (issue_ready),
    .issue_accept_i    (issue_accept),
    .issue_writeback_i (issue_wb),
    .issue_rd_i        (issue_rd),
    .issue_id_o        (issue_id),
    .issue_allow_o     (issue_allow),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .flush_i           (flush),
    .result_valid_i    (result_valid),
    .result_id_i       (result_id),
    .result_ready_o    (result_ready),
    .wb_stall_i        (wb_stall),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we),
    .rd_pending_o      (rd_pending),
    .outstanding_o     (outstanding),
    .busy_o            (busy),
    .err_o             (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the DUT result against the oldest expected result.
  task automatic sb_pop(input string tag);
    exp_res_t e;
    check({tag, "_ready"}, 32'(result_ready), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rd"}, 32'(result_rd), 32'(e.rd));
      check({tag, "_we"}, 32'(result_we), 32'(e.we));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input int exp_out, input logic [31:0] exp_pend,
                        input logic exp_err);
    check({tag, "_outstanding"}, 32'(outstanding), 32'(exp_out));
    check({tag, "_busy"}, 32'(busy), 32'(exp_out != 0));
    check({tag, "_allow"}, 32'(issue_allow), 32'(exp_out < NUM));
    check({tag, "_pending"}, rd_pending, exp_pend);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; issue_ready = 0; issue_accept = 0; issue_wb = '0; issue_rd = '0;
    commit_valid = 0; commit_id = '0; commit_kill = 0; flush = 0;
    result_valid = 0; result_id = '0; wb_stall = 0;
    #12;
    // reset state
    status("reset", 0, 32'h0, 1'b0);
    check("reset_id", 32'(issue_id), 32'd0);
    check("reset_ready", 32'(result_ready), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // rejected offload consumes nothing
    issue_valid = 1; issue_ready = 1; issue_accept = 0; issue_rd = 5'd5; issue_wb = 2'b01;
    tick();
    issue_valid = 0;
    check("reject_id", 32'(issue_id), 32'd0);
    status("reject", 0, 32'h0, 1'b0);

    // fill all four entries
    for (int k = 0; k < NUM; k++) begin
      check($sformatf("alloc_id%0d", k), 32'(issue_id), 32'(k));
      issue_valid = 1; issue_accept = 1; issue_rd = 5'(5 + k); issue_wb = 2'b01;
      tick();
    end
    issue_valid = 0;
    status("full", 4, 32'h1E0, 1'b0);

    // kill id1
    commit_valid = 1; commit_id = 4'd1; commit_kill = 1;
    tick();
    commit_valid = 0; commit_kill = 0;
    status("kill", 3, 32'h1A0, 1'b0);
    check("kill_id", 32'(issue_id), 32'd1);

    // result for the killed id is a protocol error
    result_valid = 1; result_id = 4'd1;
    #1 check("killed_ready", 32'(result_ready), 32'd0);
    tick();
    result_valid = 0;
    check("killed_err", 32'(err), 32'd1);

    // commit id0 with result offered in the same cycle
    commit_valid = 1; commit_id = 4'd0; commit_kill = 0;
    sb_q.push_back('{rd: 5'd5, we: 2'b01});
    result_valid = 1; result_id = 4'd0;
    #1 check("samecyc_ready", 32'(result_ready), 32'd0);
    check("samecyc_we", 32'(result_we), 32'd0);
    tick();
    commit_valid = 0;
    #1 sb_pop("res0");
    tick();
    result_valid = 0;
    status("res0_done", 2, 32'h180, 1'b1);

    // writeback stall holds off the result
    commit_valid = 1; commit_id = 4'd2;
    sb_q.push_back('{rd: 5'd7, we: 2'b01});
    tick();
    commit_valid = 0;
    wb_stall = 1; result_valid = 1; result_id = 4'd2;
    #1 check("stall_ready", 32'(result_ready), 32'd0);
    check("stall_we", 32'(result_we), 32'd0);
    tick();
    check("stall_ready2", 32'(result_ready), 32'd0);
    check("stall_pending", rd_pending, 32'h180);
    wb_stall = 0;
    #1 sb_pop("res2");
    tick();
    result_valid = 0;
    status("res2_done", 1, 32'h100, 1'b1);

    // register-pair and x0 writeback
    check("pair_id", 32'(issue_id), 32'd0);
    issue_valid = 1; issue_accept = 1; issue_rd = 5'd10; issue_wb = 2'b11;
    tick();
    check("x0_id", 32'(issue_id), 32'd1);
    issue_rd = 5'd0; issue_wb = 2'b01;
    tick();
    issue_valid = 0;
    status("pair", 3, 32'hD00, 1'b1);

    // flush with a simultaneous commit of id3
    commit_valid = 1; commit_id = 4'd3; commit_kill = 0; flush = 1;
    sb_q.push_back('{rd: 5'd8, we: 2'b01});
    tick();
    commit_valid = 0; flush = 0;
    status("flush", 1, 32'h100, 1'b1);
    check("flush_id", 32'(issue_id), 32'd0);
    result_valid = 1; result_id = 4'd3;
    #1 sb_pop("res3");
    tick();
    result_valid = 0;
    status("drained", 0, 32'h0, 1'b1);

    // asynchronous reset mid-transaction drops entries and clears err
    issue_valid = 1; issue_accept = 1; issue_rd = 5'd9; issue_wb = 2'b01;
    tick();
    issue_valid = 0;
    check("pre_rst_out", 32'(outstanding), 32'd1);
    #2 rst_n = 1'b0;
    #1 status("async_rst", 0, 32'h0, 1'b0);
    check("async_rst_id", 32'(issue_id), 32'd0);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cve2_xif_offload_tracker.md
# cve2_xif_offload_tracker

Core-side bookkeeping for instructions offloaded over the CORE-V XIF eXtension interface. Allocates offload IDs and tracks up to X_NUM_OUTSTANDING in-flight instructions through issue, commit/kill and result. Exposes a per-register pending-writeback scoreboard for hazard stalls and gates result acceptance. Sits in the CVE2 ID/EX stage between the decoder's offload path and the `cpu_issue`/`cpu_commit`/`cpu_result` modports; it snoops those channels and does not drive the coprocessor.

## Interface
- X_ID_WIDTH, 4: width of XIF id; must satisfy 2^X_ID_WIDTH ≥ X_NUM_OUTSTANDING.
- X_NUM_OUTSTANDING, 4: tracker entries, range 1..16.
- X_DUALWRITE, 0: 1 = register-pair writeback supported.

Ports:
- clk_i  in  1  clock; the only clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- issue_valid_i  in  1  XIF issue_valid as driven by the core.
- issue_ready_i  in  1  XIF issue_ready from the coprocessor.
- issue_accept_i  in  1  issue_resp.accept.
- issue_writeback_i  in  X_DUALWRITE+1  issue_resp.writeback.
- issue_rd_i  in  5  rd field of the offered instruction.
- issue_id_o  out  X_ID_WIDTH  ID the core must place in issue_req.id.
- issue_allow_o  out  1  a free entry exists; the core must not raise issue_valid while low.
- commit_valid_i  in  1  XIF commit_valid.
- commit_id_i  in  X_ID_WIDTH  commit.id.
- commit_kill_i  in  1  commit.commit_kill.
- flush_i  in  1  pipeline flush; kills all uncommitted entries.
- result_valid_i  in  1  XIF result_valid.
- result_id_i  in  X_ID_WIDTH  result.id.
- result_ready_o  out  1  XIF result_ready.
- wb_stall_i  in  1  core writeback port busy.
- result_rd_o  out  5  rd recorded for result_id_i.
- result_we_o  out  X_DUALWRITE+1  writeback flags recorded for result_id_i, masked by handshake.
- rd_pending_o  out  32  scoreboard; bit n set = x_n awaits writeback.
- outstanding_o  out  $clog2(X_NUM_OUTSTANDING+1)  count of valid entries.
- busy_o  out  1  outstanding_o ≠ 0.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- Entry fields: valid, committed, rd[4:0], wb[X_DUALWRITE:0]. Entry index = ID, zero-extended to X_ID_WIDTH.
- Allocation: issue_id_o = lowest-index free entry. issue_allow_o = any free entry. Both are combinational from registered state.
- Issue handshake (valid&ready):
  - accept=1: the entry becomes valid, uncommitted, and latches rd and wb.
  - accept=0: nothing is consumed; the same ID is offered again.
- Commit for a valid uncommitted ID:
  - kill=0: set committed.
  - kill=1: free the entry; no result is expected.
- Commit naming an invalid or already-committed ID sets err_o and is otherwise ignored.
- flush_i frees every valid uncommitted entry. Committed entries survive.
- result_ready_o = entry[result_id_i].valid & committed & !wb_stall_i.
- A result handshake frees the entry.
- A result_valid_i for an invalid or uncommitted ID sets err_o. result_ready_o stays 0 for that ID.
- rd_pending_o: OR over valid entries with wb[0] of onehot(rd).
  - With X_DUALWRITE and wb[1]: also set bit rd|1.
  - Bit 0 is forced to 0.
- err_o clears only on reset.

## Timing
- Reset state: all entries invalid, err_o=0, result_ready_o=0, rd_pending_o=0, outstanding_o=0, busy_o=0, issue_allow_o=1, issue_id_o=0.
- All state updates take effect at the clock edge after the event; visible one cycle later.
- The earliest commit is the cycle after issue, and the earliest result handshake is the cycle after commit. Commit and result for one ID in the same cycle: the result is not accepted (ready uses registered committed).
- An entry freed in cycle N is allocatable in N+1, never in N.
- Same cycle, different IDs: issue, commit and result are all applied. outstanding_o changes by (+alloc − kills − flushed − result).
- Commit and flush together: commit is applied first, then flush. Commit kill=0 plus flush therefore leaves the entry committed.
- Full: issue_allow_o=0. An issue handshake while full sets err_o and allocates nothing.
- Asynchronous reset mid-transaction drops all entries immediately. The coprocessor is reset alongside.

## Structure
- Package cve2_xif_pkg holds:
  - typedef xif_entry_t {valid, committed, rd, wb};
  - constant XIF_MAX_OUTSTANDING = 16;
  - function rd_onehot.
- One sub-module, cve2_xif_prio_enc: parametrised lowest-set-bit encoder producing the free index plus a found flag.

## Test plan
- Reset, then issue 4 accepted offloads with rd=5,6,7,8 and wb=1 → IDs 0,1,2,3; rd_pending_o=0x1E0; issue_allow_o=0; outstanding_o=4.
- Issue with accept=0 → issue_id_o stays 0 next cycle; outstanding_o unchanged.
- Commit id1 kill=1 → next cycle bit 6 clears and issue_id_o=1. Result for id1 → err_o=1, result_ready_o=0.
- Commit id0 kill=0; result id0 same cycle → ready=0. Next cycle ready=1 and result_rd_o=5; after the handshake bit 5 clears. With wb_stall_i=1, ready stays 0 until the stall drops.
- Two entries uncommitted + flush_i with a simultaneous commit of one → only the committed entry remains; outstanding_o=1.
- X_DUALWRITE=1, rd=10 with wb=2'b11 → rd_pending_o bits 10 and 11 set. rd=0 with wb=1 → bit 0 stays 0.
